// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio sample fetch path.
// AUDIO_FETCH_LOOP_EN is consumed by audio_sample_fetcher, not here.
package audio_pkg;

  localparam int DEFAULT_BIT_DEPTH = 16;
  localparam int DEFAULT_TRACK_LEN = 220500;
  localparam int TRACK_W           = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PLAY,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/audio_sample_fetcher_sample_fifo.sv
// First-word-fall-through FIFO holding fetched PCM samples; head reads 0 when empty.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_BIT_DEPTH,
  parameter int DEPTH = 4
) (
  input  logic                     MCLK,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  // A push into a full FIFO is legal only when the head leaves in the same edge.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL) | do_pop);
  assign head    = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge MCLK) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge MCLK) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/audio_sample_fetcher.sv
// Streams one track from sample memory into a FWFT FIFO for the I2S serializer.
// Define AUDIO_FETCH_LOOP_EN to wrap the track endlessly instead of single-shot playback.
module audio_sample_fetcher
  import audio_pkg::*;
#(
  parameter int BIT_DEPTH  = DEFAULT_BIT_DEPTH,
  parameter int ADDR_W     = 18,
  parameter int TRACK_LEN  = DEFAULT_TRACK_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      MCLK,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [TRACK_W-1:0]        track_sel,
  output logic                      mem_rd,
  output logic [TRACK_W+ADDR_W-1:0] mem_addr,
  input  logic [BIT_DEPTH-1:0]      mem_rdata,
  input  logic                      smp_req,
  output logic [BIT_DEPTH-1:0]      smp_data,
  output logic                      smp_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      underrun
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = ADDR_W + 1;
  localparam logic [CW:0] DEPTH_X = (CW + 1)'(FIFO_DEPTH);
`ifdef AUDIO_FETCH_LOOP_EN
  localparam logic [OW-1:0] LAST_OFS = OW'(TRACK_LEN - 1);
`else
  localparam logic [OW-1:0] END_OFS = OW'(TRACK_LEN);
`endif

  fetch_state_t       state;
  logic               prev_enable;
  logic               inflight;
  logic [TRACK_W-1:0] track;
  logic [OW-1:0]      ofs;
  logic [CW-1:0]      count;

  logic               rise;
  logic               active;
  logic               flush;
  logic               push;
  logic               pop_ok;
  logic               at_end;
  logic               issue;
  logic [TRACK_W-1:0] track_cur;
  logic [OW-1:0]      ofs_cur;
  logic [OW-1:0]      ofs_after;
  logic [CW:0]        count_next;

  assign smp_valid = (count != '0);

  // Fetch decision looks at the FIFO occupancy after this edge so mem_rd can be registered.
  always_comb begin
    rise       = enable & ~prev_enable;
    active     = enable & ((state == FILL) | (state == PLAY) | ((state == IDLE) & rise));
    flush      = (state == IDLE) ? rise : ~enable;
    push       = inflight;
    pop_ok     = smp_req & smp_valid;
    track_cur  = rise ? track_sel : track;
    ofs_cur    = rise ? '0 : ofs;
    count_next = flush ? '0 : ({1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop_ok));
`ifdef AUDIO_FETCH_LOOP_EN
    at_end     = 1'b0;
    ofs_after  = (ofs_cur == LAST_OFS) ? '0 : ofs_cur + OW'(1);
`else
    at_end     = (ofs_cur == END_OFS);
    ofs_after  = ofs_cur + OW'(1);
`endif
    issue      = active & ~at_end & ((count_next + (CW + 1)'(mem_rd)) < DEPTH_X);
  end

  always_ff @(posedge MCLK) begin
    if (!rst_n) begin
      state       <= IDLE;
      prev_enable <= 1'b0;
      inflight    <= 1'b0;
      track       <= '0;
      ofs         <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      prev_enable <= enable;
      done        <= 1'b0;
      mem_rd      <= issue;
      // Dropping enable discards the return of a read still in flight.
      inflight    <= enable & mem_rd;

      if (rise) begin
        track <= track_sel;
      end
      if (issue) begin
        mem_addr <= {track_cur, ofs_cur[ADDR_W-1:0]};
        ofs      <= ofs_after;
      end

      if (rise) begin
        underrun <= 1'b0;
      end
      if (smp_req && !smp_valid) begin
        underrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state <= FILL;
            busy  <= 1'b1;
          end
        end
        FILL, PLAY: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (at_end) begin
            state <= DRAIN;
          end else if ((state == FILL) && (count_next == DEPTH_X)) begin
            state <= PLAY;
          end
        end
        DRAIN: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if ((count == '0) && !inflight) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  sample_fifo #(
    .WIDTH (BIT_DEPTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .MCLK      (MCLK),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (pop_ok),
    .head      (smp_data),
    .count     (count)
  );

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// Directed bench for audio_sample_fetcher with a pop scoreboard and a memory model.
// Expectations follow AUDIO_FETCH_LOOP_EN when it is defined for the build.
module tb_audio_sample_fetcher;

  localparam int ADDR_W    = 18;
  localparam int TRACK_LEN = 8;

  logic          MCLK = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [2:0]    track_sel;
  logic          mem_rd;
  logic [20:0]   mem_addr;
  logic [15:0]   mem_rdata;
  logic          smp_req;
  logic [15:0]   smp_data;
  logic          smp_valid;
  logic          busy;
  logic          done;
  logic          underrun;

  int            n_cmp    = 0;
  int            n_err    = 0;
  int            rd_cnt   = 0;
  int            done_cnt = 0;
  int            exp_ofs  = 0;
  logic [2:0]    exp_track = '0;
  logic [15:0]   exp_q[$];

  always #5 MCLK = ~MCLK;

  audio_sample_fetcher #(
    .BIT_DEPTH  (16),
    .ADDR_W     (ADDR_W),
    .TRACK_LEN  (TRACK_LEN),
    .FIFO_DEPTH (4)
  ) dut (
    .MCLK      (MCLK),
    .rst_n     (rst_n),
    .enable    (enable),
    .track_sel (track_sel),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .smp_req   (smp_req),
    .smp_data  (smp_data),
    .smp_valid (smp_valid),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  function automatic logic [15:0] sampleOf(input logic [2:0] trk, input int ofs);
    return {trk, 13'(ofs)};
  endfunction

  // Synchronous memory: data for a read appears the cycle after mem_rd.
  always @(posedge MCLK) begin
    if (mem_rd) mem_rdata <= {mem_addr[ADDR_W+2:ADDR_W], mem_addr[12:0]};
    else        mem_rdata <= 16'hdead;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
      else begin
        n_err++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Every issued read must follow the bench's own offset sequence for the current track.
  always @(negedge MCLK) begin
    if (rst_n === 1'b1 && mem_rd === 1'b1) begin
      checkOutput("mem_addr", 32'(mem_addr), 32'({exp_track, ADDR_W'(exp_ofs)}));
      rd_cnt++;
      exp_ofs = (exp_ofs == TRACK_LEN - 1) ? 0 : exp_ofs + 1;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic applyStimulus(input logic en, input logic [2:0] trk, input logic req);
    enable    = en;
    track_sel = trk;
    smp_req   = req;
    @(negedge MCLK);
  endtask

  task automatic popSample(input logic [2:0] trk, input string tag);
    logic [15:0] want;
    want = 'x;
    if (exp_q.size() > 0) want = exp_q.pop_front();
    checkOutput({tag, "_valid"}, 32'(smp_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(smp_data), 32'(want));
    applyStimulus(1'b1, trk, 1'b1);
  endtask

  task automatic startTrack(input logic [2:0] trk, input int n);
    exp_q.delete();
    exp_track = trk;
    exp_ofs   = 0;
    for (int k = 0; k < n; k++) exp_q.push_back(sampleOf(trk, k % TRACK_LEN));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    track_sel = '0;
    smp_req = 1'b0;
    @(negedge MCLK);
    repeat (3) applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_smp_valid", 32'(smp_valid), 32'd0);
    checkOutput("rst_smp_data", 32'(smp_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b0);

    // Playback of track 3: fill timing, then steady pops every 32 cycles.
`ifdef AUDIO_FETCH_LOOP_EN
    startTrack(3'd3, 12);
`else
    startTrack(3'd3, TRACK_LEN);
`endif
    applyStimulus(1'b1, 3'd3, 1'b0);
    checkOutput("fill_busy", 32'(busy), 32'd1);
    checkOutput("fill_rd0", 32'(mem_rd), 32'd1);
    checkOutput("fill_valid_c1", 32'(smp_valid), 32'd0);
    applyStimulus(1'b1, 3'd3, 1'b0);
    checkOutput("fill_valid_c2", 32'(smp_valid), 32'd0);
    applyStimulus(1'b1, 3'd3, 1'b0);
    checkOutput("fill_valid_c3", 32'(smp_valid), 32'd1);
    checkOutput("fill_head_c3", 32'(smp_data), 32'(sampleOf(3'd3, 0)));
    applyStimulus(1'b1, 3'd3, 1'b0);
    checkOutput("fill_rd3", 32'(mem_rd), 32'd1);
    applyStimulus(1'b1, 3'd3, 1'b0);
    checkOutput("fill_stop", 32'(mem_rd), 32'd0);
    checkOutput("fill_rd_cnt", 32'(rd_cnt), 32'd4);

`ifdef AUDIO_FETCH_LOOP_EN
    for (int p = 0; p < 10; p++) begin
      repeat (31) applyStimulus(1'b1, 3'd3, 1'b0);
      popSample(3'd3, "loop_pop");
    end
    repeat (10) applyStimulus(1'b1, 3'd3, 1'b0);
    checkOutput("loop_no_done", 32'(done_cnt), 32'd0);
    checkOutput("loop_busy", 32'(busy), 32'd1);
    checkOutput("loop_underrun", 32'(underrun), 32'd0);
    applyStimulus(1'b0, 3'd3, 1'b0);
    checkOutput("loop_stop_busy", 32'(busy), 32'd0);
    checkOutput("loop_stop_valid", 32'(smp_valid), 32'd0);
`else
    for (int p = 0; p < TRACK_LEN; p++) begin
      repeat (31) applyStimulus(1'b1, 3'd3, 1'b0);
      popSample(3'd3, "play_pop");
    end
    for (int i = 0; i < 10 && done !== 1'b1; i++) applyStimulus(1'b1, 3'd3, 1'b0);
    checkOutput("end_done", 32'(done), 32'd1);
    checkOutput("end_busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 3'd3, 1'b0);
    checkOutput("end_done_pulse", 32'(done), 32'd0);
    repeat (20) applyStimulus(1'b1, 3'd3, 1'b0);
    checkOutput("end_idle_busy", 32'(busy), 32'd0);
    checkOutput("end_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("end_rd_cnt", 32'(rd_cnt), 32'(TRACK_LEN));
    checkOutput("end_no_rd", 32'(mem_rd), 32'd0);
    checkOutput("end_underrun", 32'(underrun), 32'd0);
    applyStimulus(1'b0, 3'd3, 1'b0);
`endif

    // Track 5: pop on an empty FIFO, then abort mid-play with a read in flight.
    done_cnt = 0;
    startTrack(3'd5, TRACK_LEN);
    applyStimulus(1'b1, 3'd5, 1'b0);
    checkOutput("ur_valid_first", 32'(smp_valid), 32'd0);
    applyStimulus(1'b1, 3'd5, 1'b1);
    checkOutput("ur_set", 32'(underrun), 32'd1);
    repeat (6) applyStimulus(1'b1, 3'd5, 1'b0);
    checkOutput("ur_sticky", 32'(underrun), 32'd1);
    checkOutput("full_no_rd", 32'(mem_rd), 32'd0);
    popSample(3'd5, "abort_pop");
    checkOutput("refill_rd", 32'(mem_rd), 32'd1);
    applyStimulus(1'b0, 3'd5, 1'b0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_rd", 32'(mem_rd), 32'd0);
    checkOutput("abort_valid", 32'(smp_valid), 32'd0);
    checkOutput("abort_data", 32'(smp_data), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    applyStimulus(1'b0, 3'd5, 1'b0);
    checkOutput("abort_late_drop", 32'(smp_valid), 32'd0);
    checkOutput("abort_ur_kept", 32'(underrun), 32'd1);
    checkOutput("abort_done_cnt", 32'(done_cnt), 32'd0);

    // Replay on track 2: the new edge clears underrun and restarts at offset 0.
    startTrack(3'd2, TRACK_LEN);
    applyStimulus(1'b1, 3'd2, 1'b0);
    checkOutput("replay_ur_clr", 32'(underrun), 32'd0);
    checkOutput("replay_busy", 32'(busy), 32'd1);
    checkOutput("replay_rd", 32'(mem_rd), 32'd1);
    applyStimulus(1'b1, 3'd2, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0);
    popSample(3'd2, "replay_pop");
    applyStimulus(1'b0, 3'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
